// File: rtl/fir_mac_engine_if.sv
// Simple register bus between Axi4LiteSupporter and the FIR engine.
// The master side drives addresses, data and strobes; the slave answers reads combinationally.
interface fir_mac_engine_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic [DATA_WIDTH-1:0] rdData;
  logic                  rd;

  modport master (output wrAddr, wrData, wr, rdAddr, rd, input rdData);
  modport slave  (input wrAddr, wrData, wr, rdAddr, rd, output rdData);
endinterface

// File: rtl/fir_mac_engine.sv
// Single-channel FIR engine: coefficient RAM, circular sample buffer and one MAC per cycle.
// Each accepted sample runs one full pass; the rounded result is held in a valid-flagged register.
module fir_mac_engine #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_TAPS     = 61,
  parameter int SAMPLE_WIDTH = 16,
  parameter int ACC_WIDTH    = 40,
  parameter int FRAC_BITS    = 15
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESET,
  fir_mac_engine_if.slave     bus,
  output logic                busy,
  output logic                irq,
  output logic [3:0]          marker
);

  localparam int PTR_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int PROD_W = 2 * SAMPLE_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] A_COEF   = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_SAMPLE = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_RESULT = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h10);

  localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH+1)'(1) << (FRAC_BITS-1);
  localparam logic signed [ACC_WIDTH:0] SAT_MAX  =
    (ACC_WIDTH+1)'((64'sd1 <<< (SAMPLE_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN  = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, ACCU, ROUND} state_e;

  logic signed [SAMPLE_WIDTH-1:0] coef_mem [NUM_TAPS];
  logic signed [SAMPLE_WIDTH-1:0] samp_mem [NUM_TAPS];

  state_e                         state_q, state_d;
  logic [PTR_W-1:0]               coef_ptr_q, coef_ptr_d;
  logic [PTR_W-1:0]               samp_ptr_q, samp_ptr_d;
  logic [PTR_W-1:0]               k_q, k_d;
  logic [PTR_W-1:0]               idx_q, idx_d;
  logic                           issue_done_q, issue_done_d;
  logic signed [PROD_W-1:0]       prod_q, prod_d;
  logic                           prod_vld_q, prod_vld_d;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic signed [SAMPLE_WIDTH-1:0] result_q, result_d;
  logic                           result_valid_q, result_valid_d;
  logic                           sat_en_q, sat_en_d;
  logic                           irq_en_q, irq_en_d;
  logic [3:0]                     marker_q, marker_d;
  logic                           overrun_q, overrun_d;
  logic                           coef_err_q, coef_err_d;
  logic [7:0]                     ovr_cnt_q, ovr_cnt_d;

  logic wr_coef, wr_samp, wr_ctrl, rd_result, idle, coef_we, samp_we;
  logic signed [ACC_WIDTH:0]      rnd_sum, rnd_sh;
  logic signed [SAMPLE_WIDTH-1:0] rnd_val;
  logic [DATA_WIDTH-1:0]          rd_data;
  logic                           unused_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_TAPS-1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(NUM_TAPS-1) : p - PTR_W'(1);
  endfunction

  assign idle      = (state_q == IDLE);
  assign wr_coef   = bus.wr && (bus.wrAddr == A_COEF);
  assign wr_samp   = bus.wr && (bus.wrAddr == A_SAMPLE);
  assign wr_ctrl   = bus.wr && (bus.wrAddr == A_CTRL);
  assign rd_result = bus.rd && (bus.rdAddr == A_RESULT);
  assign coef_we   = wr_coef && idle;
  assign samp_we   = wr_samp && idle;
  assign unused_wdata = ^bus.wrData;

  // Round half up, then either clamp or wrap to the sample width.
  always_comb begin
    rnd_sum = $signed({acc_q[ACC_WIDTH-1], acc_q}) + RND_HALF;
    rnd_sh  = rnd_sum >>> FRAC_BITS;
    rnd_val = rnd_sh[SAMPLE_WIDTH-1:0];
    if (sat_en_q) begin
      if (rnd_sh > SAT_MAX)      rnd_val = SAT_MAX[SAMPLE_WIDTH-1:0];
      else if (rnd_sh < SAT_MIN) rnd_val = SAT_MIN[SAMPLE_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    coef_ptr_d     = coef_ptr_q;
    samp_ptr_d     = samp_ptr_q;
    k_d            = k_q;
    idx_d          = idx_q;
    issue_done_d   = issue_done_q;
    prod_d         = prod_q;
    prod_vld_d     = 1'b0;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    sat_en_d       = sat_en_q;
    irq_en_d       = irq_en_q;
    marker_d       = marker_q;
    overrun_d      = overrun_q;
    coef_err_d     = coef_err_q;
    ovr_cnt_d      = ovr_cnt_q;

    if (rd_result) result_valid_d = 1'b0;

    // Multiply is registered, so the pass drains one extra cycle before ROUND.
    case (state_q)
      IDLE: begin
        if (samp_we) begin
          idx_d        = samp_ptr_q;
          samp_ptr_d   = ptr_inc(samp_ptr_q);
          k_d          = '0;
          acc_d        = '0;
          issue_done_d = 1'b0;
          state_d      = ACCU;
        end
      end
      ACCU: begin
        if (!issue_done_q) begin
          prod_d     = PROD_W'(coef_mem[k_q]) * PROD_W'(samp_mem[idx_q]);
          prod_vld_d = 1'b1;
          k_d        = k_q + PTR_W'(1);
          idx_d      = ptr_dec(idx_q);
          if (k_q == PTR_W'(NUM_TAPS-1)) issue_done_d = 1'b1;
        end
        if (prod_vld_q) acc_d = acc_q + ACC_WIDTH'(prod_q);
        if (issue_done_q) state_d = ROUND;
      end
      ROUND: begin
        result_d       = rnd_val;
        result_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (coef_we) coef_ptr_d = ptr_inc(coef_ptr_q);
    if (wr_coef && !idle) coef_err_d = 1'b1;
    if (wr_samp && !idle) begin
      overrun_d = 1'b1;
      if (ovr_cnt_q != 8'hFF) ovr_cnt_d = ovr_cnt_q + 8'd1;
    end

    // Pointer clear leaves idx alone so an in-flight pass completes unchanged.
    if (wr_ctrl) begin
      sat_en_d = bus.wrData[0];
      irq_en_d = bus.wrData[3];
      marker_d = bus.wrData[7:4];
      if (bus.wrData[1]) begin
        coef_ptr_d = '0;
        samp_ptr_d = '0;
      end
      if (bus.wrData[2]) begin
        overrun_d  = 1'b0;
        coef_err_d = 1'b0;
        ovr_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q        <= IDLE;
      coef_ptr_q     <= '0;
      samp_ptr_q     <= '0;
      k_q            <= '0;
      idx_q          <= '0;
      issue_done_q   <= 1'b0;
      prod_q         <= '0;
      prod_vld_q     <= 1'b0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sat_en_q       <= 1'b1;
      irq_en_q       <= 1'b0;
      marker_q       <= '0;
      overrun_q      <= 1'b0;
      coef_err_q     <= 1'b0;
      ovr_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      coef_ptr_q     <= coef_ptr_d;
      samp_ptr_q     <= samp_ptr_d;
      k_q            <= k_d;
      idx_q          <= idx_d;
      issue_done_q   <= issue_done_d;
      prod_q         <= prod_d;
      prod_vld_q     <= prod_vld_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      sat_en_q       <= sat_en_d;
      irq_en_q       <= irq_en_d;
      marker_q       <= marker_d;
      overrun_q      <= overrun_d;
      coef_err_q     <= coef_err_d;
      ovr_cnt_q      <= ovr_cnt_d;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (coef_we) coef_mem[coef_ptr_q] <= bus.wrData[SAMPLE_WIDTH-1:0];
    if (samp_we) samp_mem[samp_ptr_q] <= bus.wrData[SAMPLE_WIDTH-1:0];
  end

  always_comb begin
    rd_data = '0;
    case (bus.rdAddr)
      A_RESULT: begin
        rd_data[DATA_WIDTH-2:0] = (DATA_WIDTH-1)'(result_q);
        rd_data[DATA_WIDTH-1]   = result_valid_q;
      end
      A_CTRL: begin
        rd_data[0]   = sat_en_q;
        rd_data[3]   = irq_en_q;
        rd_data[7:4] = marker_q;
      end
      A_STATUS: begin
        rd_data[DATA_WIDTH-1] = busy;
        rd_data[DATA_WIDTH-2] = overrun_q;
        rd_data[DATA_WIDTH-3] = coef_err_q;
        rd_data[15:8]         = ovr_cnt_q;
        rd_data[7:0]          = 8'(samp_ptr_q);
      end
      default: rd_data = '0;
    endcase
  end

  assign bus.rdData = rd_data;
  assign busy       = (state_q != IDLE);
  assign irq        = result_valid_q && irq_en_q;
  assign marker     = marker_q;

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Parametrised successor to the single-channel AXI4-Lite FIR filter core.
- Sits behind Axi4LiteSupporter on the simple bus (wrAddr/wrData/wr/rdAddr/rdData/rd).
- Holds NUM_TAPS coefficients and a circular sample buffer. Each accepted sample write auto-starts one multiply-accumulate pass.
- Result is rounded and optionally saturated, then held in a valid-flagged result register. Adds busy/overrun status, an interrupt, and a control register for saturation mode, pointer clear and timing markers.

Parameters:
- ADDR_WIDTH, 6, simple-bus address width.
- DATA_WIDTH, 32, bus data width.
- NUM_TAPS, 61, taps and sample-buffer depth (2..256).
- SAMPLE_WIDTH, 16, signed coefficient/sample width (2..31).
- ACC_WIDTH, 40, signed accumulator width. Must be at least 2*SAMPLE_WIDTH+clog2(NUM_TAPS).
- FRAC_BITS, 15, fractional bits removed when producing the result.

Ports:
- S_AXI_ACLK  in  1  sole clock, rising edge.
- S_AXI_ARESET  in  1  reset, asynchronous, active-high.
- wrAddr  in  ADDR_WIDTH  write address.
- wrData  in  DATA_WIDTH  write data.
- wr  in  1  one-cycle write strobe.
- rdAddr  in  ADDR_WIDTH  read address.
- rdData  out  DATA_WIDTH  read data, combinational from rdAddr.
- rd  in  1  one-cycle read strobe; consume event for RESULT.
- busy  out  1  high while state is not IDLE.
- irq  out  1  result_valid AND irq_en.
- marker  out  4  CTRL[7:4], for scope timing.

Behaviour:
- Register map (byte addresses):
  - 0x00 COEF (W): coef[coef_ptr] <= wrData[SAMPLE_WIDTH-1:0]; coef_ptr advances mod NUM_TAPS.
  - 0x04 SAMPLE (W).
  - 0x08 RESULT (R).
  - 0x0C CTRL (R/W).
  - 0x10 STATUS (R).
  - Unmapped reads return 0; unmapped writes are ignored.
- CTRL:
  - bit0 sat_en (reset 1).
  - bit1 clr_ptrs, self-clearing: coef_ptr and samp_ptr go to 0.
  - bit2 clr_flags, self-clearing: overrun, coef_err and ovr_cnt go to 0.
  - bit3 irq_en (reset 0).
  - bits7:4 marker (reset 0).
  - CTRL reads return bit0, bit3 and bits7:4; bits 1 and 2 read 0.
- STATUS: bit31 busy, bit30 overrun, bit29 coef_err, bits15:8 ovr_cnt, bits7:0 samp_ptr.
- RESULT: bit31 result_valid; bits30:0 result, sign-extended to 31 bits.
- State machine IDLE -> ACCU -> ROUND -> IDLE.
  - IDLE with SAMPLE write: sample[samp_ptr] <= data. Latch newest index n = samp_ptr, advance samp_ptr mod NUM_TAPS, clear acc and tap k, go to ACCU.
  - ACCU, one tap per cycle: acc += coef[k]*sample[idx]. idx starts at n and decrements, wrapping 0 -> NUM_TAPS-1. After k = NUM_TAPS-1, go to ROUND.
  - ROUND: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, arithmetic shift.
    - sat_en=1: clamp r to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1].
    - sat_en=0: keep the low SAMPLE_WIDTH bits as signed.
    - Load result, set result_valid, go to IDLE.
- Latency: result_valid is high NUM_TAPS+2 rising edges after the edge that accepted the SAMPLE write.
- Boundary conditions:
  - SAMPLE write while busy: dropped, no pointer change. overrun set (sticky); ovr_cnt increments, saturating at 255.
  - COEF write while busy: dropped; coef_err set (sticky).
  - rd at 0x08 clears result_valid on the next edge. If ROUND loads in the same cycle, the new valid wins.
  - CTRL write while busy: takes effect immediately. sat_en is sampled in ROUND; clr_ptrs does not disturb the in-flight idx.
  - Pointer wrap: samp_ptr and coef_ptr go from NUM_TAPS-1 to 0.
- Reset (asynchronous, immediate):
  - state IDLE, busy 0, irq 0, pointers 0, acc/result 0, result_valid 0.
  - Flags and ovr_cnt 0, sat_en 1, irq_en 0, marker 0.
  - A pass in progress is aborted.
  - coef and sample memories are not reset; their contents are undefined.

Test Plan:
- Rounding: NUM_TAPS default, coef[0]=1 and rest 0, 61 zero samples, each run to completion.
  - sample 16384 -> RESULT 0x80000001.
  - sample -16384 -> 0x80000000.
  - sample 16383 -> 0x80000000.
- Saturation: all coefs and samples 32767.
  - sat_en=1 -> RESULT 0x80007FFF.
  - sat_en=0 -> 0x80007F86.
- Latency/irq: irq_en=1, SAMPLE write accepted at edge E0.
  - busy is high from E0 until ROUND completes.
  - result_valid and irq rise at edge E0+63.
  - rd at 0x08 -> both drop next edge; a re-read shows bit31=0.
- Overrun: SAMPLE write, a second SAMPLE write 5 cycles later.
  - STATUS bit30=1, ovr_cnt=1, samp_ptr advanced by 1 only.
  - Result equals the single-sample value.
  - clr_flags -> STATUS bits 30, 29 and 15:8 read 0.
- Wrap: coefs 0x0100 at k=0 and 0 elsewhere; clr_ptrs; 62 SAMPLE writes of value i (i=1..62).
  - samp_ptr is 1 after the writes.
  - Last result is 62*256/32768 rounded = 0, confirming index-0 reuse.
  - Repeat with the coefficient 0x4000 at k=0: result 31.
- Async reset: assert S_AXI_ARESET 10 cycles into ACCU.
  - busy, irq and result_valid are 0 before the next clock edge.
  - STATUS reads 0; CTRL reads 0x01.
